// File: rtl/psec6_refclk_pkg.sv
// Shared definitions for the reference-clock divider selection logic.
// Provides the divider count, the highest legal selection code, the
// sequencer state encoding and a legality check for selection codes.
package psec6_refclk_pkg;

  // Five divider tgates: code 0 -> /512 ... code 4 -> /32
  localparam int NUM_DIV = 5;
  localparam logic [2:0] SEL_MAX = 3'd4;

  // Fixed encodings kept for compatibility with older netlists and probes
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BREAK = 2'd1;
  localparam logic [1:0] ST_MAKE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BREAK = ST_BREAK,
    MAKE  = ST_MAKE
  } state_e;

  // Codes 5..7 have no divider behind them
  function automatic logic sel_legal(input logic [2:0] code);
    return code <= SEL_MAX;
  endfunction

endpackage

// File: rtl/ref_clk_sel_decoder.sv
// Combinational decoder from a selection code to one-hot divider tgate enables.
// Ports:
//   rst   - forces every enable low when high
//   sel   - selection code, 0 -> /512 ... 4 -> /32
//   gates - one-hot enables, bit0 = /512 ... bit4 = /32; all low for codes 5..7
module ref_clk_sel_decoder
  import psec6_refclk_pkg::*;
(
  input  logic               rst,
  input  logic [2:0]         sel,
  output logic [NUM_DIV-1:0] gates
);

  // Illegal codes decode to all-off so no gate can be enabled by accident
  always_comb begin
    gates = '0;
    if (!rst) begin
      case (sel)
        3'd0:    gates = 5'b00001;
        3'd1:    gates = 5'b00010;
        3'd2:    gates = 5'b00100;
        3'd3:    gates = 5'b01000;
        3'd4:    gates = 5'b10000;
        default: gates = '0;
      endcase
    end
  end

endmodule

// File: rtl/ref_clk_sel_sequencer.sv
// Break-before-make sequencer for the reference-clock divider tgates.
// A selection request is taken through a valid/ready handshake. A change
// turns every gate off for DEAD_CYCLES, then enables only the new gate and
// holds it for SETTLE_CYCLES before declaring lock.
// Ports:
//   clk, rst       - block clock, synchronous active-high reset
//   sel_req_valid  - request present; held with sel_req until accepted
//   sel_req        - requested code, 0 -> /512 ... 4 -> /32
//   sel_req_ready  - request can be accepted (IDLE and not in reset)
//   tgate_control  - registered one-hot gate enables, all low while breaking
//   cur_sel        - code in force or being applied
//   locked         - selected clock has settled
//   done           - one-cycle pulse: request completed, rejected or no-op
//   err            - one-cycle pulse: request rejected for an illegal code
module ref_clk_sel_sequencer
  import psec6_refclk_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [2:0]  RESET_SEL     = 3'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_req_valid,
  input  logic [2:0]         sel_req,
  output logic               sel_req_ready,
  output logic [NUM_DIV-1:0] tgate_control,
  output logic [2:0]         cur_sel,
  output logic               locked,
  output logic               done,
  output logic               err
);

  localparam int unsigned CNT_MAX = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_DIV-1:0] RESET_GATES = NUM_DIV'(1) << RESET_SEL;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         cur_sel_q, cur_sel_d;
  logic [NUM_DIV-1:0] tgate_q, tgate_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               rst_settle_q, rst_settle_d;
  logic [NUM_DIV-1:0] dec_gates;
  logic               accept;

  assign sel_req_ready = (state_q == IDLE) && !rst;
  assign accept        = sel_req_valid && sel_req_ready;

  ref_clk_sel_decoder u_decoder (
    .rst   (1'b0),
    .sel   (cur_sel_q),
    .gates (dec_gates)
  );

  // Next-state logic. The settle that follows reset is flagged so that its
  // completion does not produce a done pulse. The gate register takes the
  // decoded code of the register already holding the new selection, masked
  // off whenever the next state is BREAK, so the old gate drops on the
  // accepting edge and the new gate appears only on entry to MAKE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_sel_d    = cur_sel_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rst_settle_d = rst_settle_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!sel_legal(sel_req)) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (sel_req == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            cur_sel_d = sel_req;
            state_d   = BREAK;
            cnt_d     = DEAD_LOAD;
          end
        end
      end
      BREAK: begin
        if (cnt_q == '0) begin
          state_d = MAKE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MAKE: begin
        if (cnt_q == '0) begin
          state_d      = IDLE;
          done_d       = !rst_settle_q;
          rst_settle_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    tgate_d = dec_gates & {NUM_DIV{state_d != BREAK}};
  end

  // Reset loads the reset gate directly; from either BREAK (all off) or
  // MAKE (one gate) this is a single one-hot step, never multi-hot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MAKE;
      cnt_q        <= SETTLE_LOAD;
      cur_sel_q    <= RESET_SEL;
      tgate_q      <= RESET_GATES;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rst_settle_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_sel_q    <= cur_sel_d;
      tgate_q      <= tgate_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rst_settle_q <= rst_settle_d;
    end
  end

  assign tgate_control = tgate_q;
  assign cur_sel       = cur_sel_q;
  assign locked        = (state_q == IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: doc/ref_clk_sel_sequencer.md
# ref_clk_sel_sequencer

Sequences changes of the reference-clock divider selection so that the five divider transmission gates (÷32, ÷64, ÷128, ÷256, ÷512) never overlap and the new divided clock settles before anything downstream relies on it. It accepts a 3-bit selection request through a valid/ready handshake. It runs a break-before-make sequence: all gates off, then only the new gate on, then a settle interval. It reports lock status and the selection currently in force. It sits between the configuration/serial-register logic and the analog divider tgate enables.

## Interface
- DEAD_CYCLES, 4: cycles with all gates off between deselect and select; legal range ≥1.
- SETTLE_CYCLES, 16: cycles the new gate is held before lock is declared; legal range ≥1.
- RESET_SEL, 3'd1: selection applied at reset (÷256); must be 0–4.

- clk, input, 1: block clock.
- rst, input, 1: reset, synchronous, active-high.
- sel_req_valid, input, 1: a selection request is present.
- sel_req, input, 3: requested code; 0→÷512, 1→÷256, 2→÷128, 3→÷64, 4→÷32.
- sel_req_ready, output, 1: the block can accept a request.
- tgate_control, output, 5: registered one-hot gate enables; bit0=÷512 … bit4=÷32; all zero during the break phase.
- cur_sel, output, 3: the code currently selected or being applied.
- locked, output, 1: the selected clock has settled.
- done, output, 1: one-cycle pulse when a request completes, is rejected, or needs no change.
- err, output, 1: one-cycle pulse when a request is rejected for an illegal code.

## Operation
- **States:**
  - IDLE: locked=1, ready=1.
  - BREAK: all gates off, counting DEAD_CYCLES.
  - MAKE: new gate on, counting SETTLE_CYCLES.
- **Handshake:**
  - A request is accepted on a rising edge where sel_req_valid && sel_req_ready.
  - sel_req_ready = (state==IDLE) && !rst.
  - The requester holds valid and the payload stable until the request is accepted.
- **Accepted code 5–7:**
  - No state change, and tgate_control and cur_sel are unchanged.
  - Next cycle: err=1 and done=1 for one cycle; the block stays in IDLE.
- **Accepted code equal to cur_sel:**
  - No break sequence.
  - Next cycle: done=1 for one cycle; locked stays 1.
- **Accepted legal, different code:**
  - cur_sel takes the new code and the state goes to BREAK.
  - Sequence: BREAK → MAKE → IDLE.
  - locked=0 throughout BREAK and MAKE.
- **Counters:** a single down-counter of width $clog2(max(DEAD_CYCLES,SETTLE_CYCLES)+1).
  - It is loaded with N−1 on entry to each phase.
  - The phase ends when the counter reaches 0.
- **Invariant:** tgate_control is never multi-hot in any cycle, including reset and the transitions into and out of reset.

## Timing
- **Reset values** (in the cycle after the rst edge):
  - tgate_control = one-hot(RESET_SEL), i.e. 5'b00010 by default.
  - cur_sel = RESET_SEL.
  - locked=0, sel_req_ready=0, done=0, err=0.
  - state = MAKE, counter = SETTLE_CYCLES−1.
- **After reset release:**
  - locked and ready rise SETTLE_CYCLES cycles after the last rst-high edge.
  - No done pulse is produced for the reset settle.
- **Change request accepted at edge k:**
  - Cycles k+1 … k+DEAD_CYCLES: tgate_control = 0.
  - Cycles k+DEAD_CYCLES+1 … k+DEAD_CYCLES+SETTLE_CYCLES: tgate_control = new one-hot, locked=0.
  - Cycle k+DEAD_CYCLES+SETTLE_CYCLES+1: IDLE with locked=1, ready=1, done=1.
- **Back-to-back requests:** a request held during a sequence is accepted in the first IDLE cycle; done and the new acceptance may coincide.
- **rst mid-sequence:** the sequence is aborted at that edge and the reset values apply. The gates go directly from 0 (BREAK) or the new one-hot (MAKE) to one-hot(RESET_SEL), never through a multi-hot value.

## Structure
- **Package psec6_refclk_pkg:**
  - state enum typedef (IDLE, BREAK, MAKE).
  - localparam NUM_DIV=5 and SEL_MAX=3'd4.
  - function sel_legal(code).
- **Sub-module:** instantiate the existing ref_clk_sel_decoder with its rst tied low, driven by the cur_sel register.
  - tgate_control register = decoder output ANDed with (state != BREAK).
  - The decoder is not duplicated.

## Test plan
- **Reset:** rst high for 3 cycles, then low, default parameters → tgate 5'b00010 throughout; locked and ready rise exactly 16 cycles after release; no done pulse.
- **Legal change:** request code 4 from code 1 → tgate 00000 for 4 cycles, then 10000 for 16 cycles; locked=1, done=1 on cycle 21 after acceptance; cur_sel=4.
- **Illegal code:** request code 6 in IDLE → err and done pulse one cycle later; tgate remains 00010; locked stays 1.
- **Same code:** request code 1 while cur_sel=1 → done pulse only; tgate unchanged; no zero cycles.
- **Back-to-back:** valid held high with code 0, then code 3 → second request accepted the cycle its predecessor's done asserts; the full sequence repeats; tgate is never multi-hot (assertion checked every cycle).
- **Reset mid-MAKE:** assert rst during MAKE of code 2 → the next cycle shows tgate 00010, cur_sel 1, locked 0; a settle of 16 cycles follows.
